// File: rtl/div_pkg.sv
// Shared types and constants for the div_seq divide sequencer and its
// special-case resolver.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [63:0] INT64_MIN  = 64'h8000_0000_0000_0000;
  localparam logic [31:0] INT32_MIN  = 32'h8000_0000;
  localparam logic [63:0] ALL_ONES64 = 64'hFFFF_FFFF_FFFF_FFFF;

  // Latency counter width; a one-cycle latency still needs a 1-bit counter.
  function automatic int cnt_width(input int latency);
    return (latency > 1) ? $clog2(latency) : 1;
  endfunction

endpackage

// File: rtl/div_special.sv
// RISC-V signed-divide special-case resolver: divide by zero, overflow and
// DIVW sign extension applied on top of the raw divider quotient.
module div_special
  import div_pkg::*;
(
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        word,
  input  logic [63:0] quotient,
  output logic        is_special,
  output logic [63:0] final_result
);

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    is_special   = 1'b0;
    final_result = quotient;
    if (word) begin
      if (b[31:0] == 32'h0) begin
        is_special   = 1'b1;
        final_result = ALL_ONES64;
      end else if (a[31:0] == INT32_MIN && b[31:0] == 32'hFFFF_FFFF) begin
        is_special   = 1'b1;
        final_result = {32'hFFFF_FFFF, INT32_MIN};
      end else begin
        final_result = {{32{quotient[31]}}, quotient[31:0]};
      end
    end else begin
      if (b == 64'h0) begin
        is_special   = 1'b1;
        final_result = ALL_ONES64;
      end else if (a == INT64_MIN && b == ALL_ONES64) begin
        is_special   = 1'b1;
        final_result = a;
      end
    end
  end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle sequencer around the EXU's combinational signed divider.
// Optional feature macro: DIV_SPECIAL_CASE_EARLY_EN (special cases resolved at accept).
module div_seq
  import div_pkg::*;
#(
  parameter int LATENCY = 4,
  parameter int XLEN    = 64
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic            in_word,
  input  logic [4:0]      in_rd,
  input  logic            flush,
  output logic [XLEN-1:0] div_a,
  output logic [XLEN-1:0] div_b,
  output logic            div_word,
  input  logic [XLEN-1:0] div_result,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd,
  output logic            busy
);

  localparam int CNT_W = cnt_width(LATENCY);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [XLEN-1:0]   cap_result;
  logic              unused_cap_special;

  // Resolver on the registered operands; its result is what writeback sees.
  div_special u_cap (
    .a            (div_a),
    .b            (div_b),
    .word         (div_word),
    .quotient     (div_result),
    .is_special   (unused_cap_special),
    .final_result (cap_result)
  );

`ifdef DIV_SPECIAL_CASE_EARLY_EN
  logic            early_special;
  logic [XLEN-1:0] early_result;

  // Special-case results never depend on the quotient, so none is supplied.
  div_special u_early (
    .a            (in_a),
    .b            (in_b),
    .word         (in_word),
    .quotient     ({XLEN{1'b0}}),
    .is_special   (early_special),
    .final_result (early_result)
  );
`endif

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      div_a      <= '0;
      div_b      <= '0;
      div_word   <= 1'b0;
      out_rd     <= '0;
      out_result <= '0;
      out_valid  <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            div_a    <= in_a;
            div_b    <= in_b;
            div_word <= in_word;
            out_rd   <= in_rd;
            cnt      <= CNT_W'(LATENCY - 1);
            state    <= WAIT;
`ifdef DIV_SPECIAL_CASE_EARLY_EN
            if (early_special) begin
              out_result <= early_result;
              out_valid  <= 1'b1;
              state      <= DONE;
            end
`endif
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            out_result <= cap_result;
            out_valid  <= 1'b1;
            state      <= DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed corner cases plus randomized ops
// against a behavioural signed-divide model and a model of the external divider.
module tb_div_seq;

  localparam int LAT = 4;
  localparam logic [63:0] I64_MIN = 64'h8000_0000_0000_0000;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_a = '0;
  logic [63:0] in_b = '0;
  logic        in_word = 1'b0;
  logic [4:0]  in_rd = '0;
  logic        flush = 1'b0;
  logic [63:0] div_a;
  logic [63:0] div_b;
  logic        div_word;
  logic [63:0] div_result;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_result;
  logic [4:0]  out_rd;
  logic        busy;

  int total = 0;
  int bad   = 0;

  div_seq #(.LATENCY(LAT), .XLEN(64)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_word    (in_word),
    .in_rd      (in_rd),
    .flush      (flush),
    .div_a      (div_a),
    .div_b      (div_b),
    .div_word   (div_word),
    .div_result (div_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_rd     (out_rd),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  // External divider: real quotient where defined, junk elsewhere and in the
  // unused upper half of word results.
  always_comb begin
    div_result = 64'h5A5A_5A5A_5A5A_5A5A ^ div_a;
    if (div_word) begin
      if (div_b[31:0] != 32'h0 && !(div_a[31:0] == 32'h8000_0000 && div_b[31:0] == 32'hFFFF_FFFF))
        div_result = {32'hDEAD_BEEF ^ div_a[63:32],
                      32'($signed(div_a[31:0]) / $signed(div_b[31:0]))};
    end else if (div_b != 64'h0 && !(div_a == I64_MIN && div_b == '1)) begin
      div_result = $signed(div_a) / $signed(div_b);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_div(input logic [63:0] a, input logic [63:0] b, input logic w);
    longint sa, sb;
    int     wa, wb;
    if (w) begin
      wa = a[31:0];
      wb = b[31:0];
      if (wb == 0) return '1;
      if (wa == int'(32'h8000_0000) && wb == -1) return 64'hFFFF_FFFF_8000_0000;
      return longint'(wa / wb);
    end
    sa = a;
    sb = b;
    if (sb == 0) return '1;
    if (a == I64_MIN && sb == -1) return a;
    return sa / sb;
  endfunction

  function automatic bit is_spec(input logic [63:0] a, input logic [63:0] b, input logic w);
    if (w) return (b[31:0] == 32'h0) || (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
    return (b == 64'h0) || (a == I64_MIN && b == '1);
  endfunction

  // Called at a negedge in IDLE; presents a request for the next rising edge.
  task automatic start_op(input logic [63:0] a, input logic [63:0] b, input logic w,
                          input logic [4:0] rd);
    check("in_ready_idle", {63'b0, in_ready}, 64'd1);
    check("busy_idle", {63'b0, busy}, 64'd0);
    check("out_valid_idle", {63'b0, out_valid}, 64'd0);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_word = w;
    in_rd = rd;
  endtask

  task automatic finish_op(input logic [63:0] a, input logic [63:0] b, input logic w,
                           input logic [4:0] rd, input int stall);
    int          exp_k;
    logic [63:0] exp_r;
    exp_r = ref_div(a, b, w);
`ifdef DIV_SPECIAL_CASE_EARLY_EN
    exp_k = is_spec(a, b, w) ? 1 : LAT + 1;
`else
    exp_k = LAT + 1;
`endif
    for (int k = 1; k <= exp_k; k++) begin
      @(negedge clock);
      if (k == 1) begin
        // Junk on the inputs must not leak into held operands or be accepted.
        in_valid = 1'($urandom_range(0, 1));
        in_a = {$urandom, $urandom};
        in_b = {$urandom, $urandom};
        in_word = 1'($urandom_range(0, 1));
        in_rd = 5'($urandom);
      end
      check("out_valid_timing", {63'b0, out_valid}, {63'b0, (k == exp_k)});
      check("in_ready_busy", {63'b0, in_ready}, 64'd0);
      check("busy_high", {63'b0, busy}, 64'd1);
      check("div_a_held", div_a, a);
      check("div_b_held", div_b, b);
      check("div_word_held", {63'b0, div_word}, {63'b0, w});
    end
    check("result", out_result, exp_r);
    check("rd", {59'b0, out_rd}, {59'b0, rd});
    out_ready = (stall == 0);
    for (int s = 1; s <= stall; s++) begin
      @(negedge clock);
      check("bp_valid", {63'b0, out_valid}, 64'd1);
      check("bp_result", out_result, exp_r);
      check("bp_rd", {59'b0, out_rd}, {59'b0, rd});
      check("bp_in_ready", {63'b0, in_ready}, 64'd0);
      if (s == stall) out_ready = 1'b1;
    end
    @(negedge clock);
    in_valid = 1'b0;
    check("valid_after_hs", {63'b0, out_valid}, 64'd0);
    check("ready_after_hs", {63'b0, in_ready}, 64'd1);
  endtask

  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic w,
                        input logic [4:0] rd, input int stall);
    start_op(a, b, w, rd);
    finish_op(a, b, w, rd, stall);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, {63'b0, in_ready}, 64'd1);
    check({tag, "_busy"}, {63'b0, busy}, 64'd0);
    check({tag, "_out_valid"}, {63'b0, out_valid}, 64'd0);
    check({tag, "_out_result"}, out_result, 64'd0);
    check({tag, "_out_rd"}, {59'b0, out_rd}, 64'd0);
    check({tag, "_div_a"}, div_a, 64'd0);
    check({tag, "_div_b"}, div_b, 64'd0);
    check({tag, "_div_word"}, {63'b0, div_word}, 64'd0);
  endtask

  initial begin
    logic [63:0] ra, rb;
    logic        rw;
    int          sel;

    #1;
    check_reset_outputs("reset");
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // Directed corner cases.
    run_op(64'd100, -64'sd7, 1'b0, 5'd3, 0);
    run_op(64'h0000_0000_FFFF_FFF6, 64'd2, 1'b1, 5'd5, 0);
    run_op(64'd123, 64'd0, 1'b0, 5'd7, 0);
    run_op(64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 5'd9, 0);
    run_op(I64_MIN, '1, 1'b0, 5'd10, 0);
    run_op(64'd5, 64'h0000_0001_0000_0000, 1'b1, 5'd12, 0);
    run_op(64'd1000, 64'd10, 1'b0, 5'd11, 3);

    // Flush mid-WAIT: the request presented with flush is dropped, the next one is taken.
    start_op(64'd55, 64'd5, 1'b0, 5'd4);
    @(negedge clock);
    in_valid = 1'b0;
    @(negedge clock);
    flush = 1'b1;
    in_valid = 1'b1;
    in_a = 64'd77;
    in_b = 64'd7;
    in_word = 1'b0;
    in_rd = 5'd6;
    @(negedge clock);
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_wait_valid", {63'b0, out_valid}, 64'd0);
    check("flush_wait_idle", {63'b0, in_ready}, 64'd1);
    run_op(64'd77, 64'd7, 1'b0, 5'd6, 0);

    // Flush in IDLE beats a simultaneous request.
    flush = 1'b1;
    in_valid = 1'b1;
    in_a = 64'd8;
    in_b = 64'd2;
    @(negedge clock);
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_idle_busy", {63'b0, busy}, 64'd0);
    check("flush_idle_ready", {63'b0, in_ready}, 64'd1);

    // Flush in DONE drops out_valid the following cycle.
    start_op(64'd9, 64'd2, 1'b0, 5'd1);
    out_ready = 1'b0;
    @(negedge clock);
    in_valid = 1'b0;
    repeat (LAT) @(negedge clock);
    check("done_before_flush", {63'b0, out_valid}, 64'd1);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    out_ready = 1'b1;
    check("flush_done_valid", {63'b0, out_valid}, 64'd0);
    check("flush_done_busy", {63'b0, busy}, 64'd0);

    // Asynchronous reset mid-WAIT.
    start_op(64'd200, 64'd3, 1'b0, 5'd2);
    @(negedge clock);
    in_valid = 1'b0;
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    run_op(64'd200, 64'd3, 1'b0, 5'd2, 0);

    // Randomized ops with biased special cases and random backpressure.
    for (int n = 0; n < 40; n++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rw = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 7);
      if (sel == 0) begin
        if (rw) rb[31:0] = 32'h0;
        else rb = 64'h0;
      end else if (sel == 1) begin
        if (rw) begin
          ra[31:0] = 32'h8000_0000;
          rb[31:0] = 32'hFFFF_FFFF;
        end else begin
          ra = I64_MIN;
          rb = '1;
        end
      end else if (sel == 2) begin
        rb = {{56{rb[7]}}, rb[7:0]};
      end
      run_op(ra, rb, rw, 5'($urandom), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
